// File: rtl/dqn_pkg.sv
// Shared DQN datapath definitions: Q8.8 format, layer sizes and saturation limits.
package dqn_pkg;

  localparam int Q_FRAC = 8;   // fractional bits of Q8.8
  localparam int N_HID  = 9;   // hidden units including bias
  localparam int N_ACT  = 5;   // actions / Q-value outputs

  typedef logic signed [15:0] q88_t;

  localparam q88_t Q88_MAX = 16'sh7FFF;
  localparam q88_t Q88_MIN = 16'sh8000;

  // Sign-extend a Q8.8 value to a 36-bit accumulator-sized word.
  function automatic logic signed [35:0] q88_sext36(input q88_t v);
    return {{20{v[15]}}, v};
  endfunction

endpackage

// File: rtl/q88_shift_sat.sv
// Rescale a wide accumulator back to Q8.8: arithmetic right shift by FRAC
// (floor, no rounding) followed by saturation to the signed 16-bit range.
module q88_shift_sat
  import dqn_pkg::*;
#(
  parameter int ACC_W = 36,
  parameter int FRAC  = 8
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output q88_t                    o_q
);

  logic signed [ACC_W-1:0] w_shift;
  logic signed [ACC_W-1:0] w_max;
  logic signed [ACC_W-1:0] w_min;

  assign w_shift = i_acc >>> FRAC;
  assign w_max   = {{(ACC_W-16){Q88_MAX[15]}}, Q88_MAX};
  assign w_min   = {{(ACC_W-16){Q88_MIN[15]}}, Q88_MIN};

  // Clamp the shifted value into [Q88_MIN, Q88_MAX].
  always_comb begin
    o_q = Q88_MIN;
    if (w_shift > w_max) begin
      o_q = Q88_MAX;
    end else if (w_shift < w_min) begin
      o_q = Q88_MIN;
    end else begin
      o_q = w_shift[15:0];
    end
  end

endmodule

// File: rtl/qlayer2_fwd.sv
// Layer-2 forward pass of the DQN datapath. Walks the hidden index 0..N_HID-1,
// multiply-accumulates five Q-value sums from the weight store outputs and the
// hidden activation, then rescales/saturates them to Q8.8 in a final cycle.
// Optional: define QLAYER2_ARGMAX_EN to add the registered `action` argmax output.
module qlayer2_fwd
  import dqn_pkg::q88_t, dqn_pkg::N_ACT;
#(
  parameter int FRAC  = 8,
  parameter int N_HID = 9,
  parameter int ACC_W = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] h_in,
  input  logic signed [15:0] w2_1,
  input  logic signed [15:0] w2_2,
  input  logic signed [15:0] w2_3,
  input  logic signed [15:0] w2_4,
  input  logic signed [15:0] w2_5,
  output logic [3:0]         idx,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] q_1,
  output logic signed [15:0] q_2,
  output logic signed [15:0] q_3,
  output logic signed [15:0] q_4,
  output logic signed [15:0] q_5
`ifdef QLAYER2_ARGMAX_EN
  ,
  output logic [2:0]         action
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(N_HID - 1);

  logic [1:0]              r_state;
  logic [3:0]              r_idx;
  logic                    r_busy;
  logic                    r_done;
  logic signed [ACC_W-1:0] r_acc [N_ACT];
  q88_t                    r_q   [N_ACT];

  q88_t                    w_w2       [N_ACT];
  logic signed [ACC_W-1:0] w_prod_ext [N_ACT];
  q88_t                    w_sat      [N_ACT];

  assign w_w2[0] = w2_1;
  assign w_w2[1] = w2_2;
  assign w_w2[2] = w2_3;
  assign w_w2[3] = w2_4;
  assign w_w2[4] = w2_5;

  // One multiplier and one rescale/saturate unit per Q-value lane.
  for (genvar g = 0; g < N_ACT; g++) begin : g_lane
    logic signed [31:0] w_prod;
    assign w_prod        = w_w2[g] * h_in;
    assign w_prod_ext[g] = {{(ACC_W-32){w_prod[31]}}, w_prod};

    q88_shift_sat #(
      .ACC_W (ACC_W),
      .FRAC  (FRAC)
    ) u_sat (
      .i_acc (r_acc[g]),
      .o_q   (w_sat[g])
    );
  end

  // Pass sequencing: IDLE waits for start, RUN walks idx, FIN publishes results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_idx   <= 4'd0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= 4'd0;
          end
        end
        S_RUN: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= 4'd0;
            r_state <= S_FIN;
          end else begin
            r_idx   <= r_idx + 4'd1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= 4'd0;
        end
      endcase
    end
  end

  // Accumulators: cleared on pass start, one MAC per lane on each RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_ACT; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < N_ACT; k++) begin
              r_acc[k] <= '0;
            end
          end
        end
        S_RUN: begin
          for (int k = 0; k < N_ACT; k++) begin
            r_acc[k] <= r_acc[k] + w_prod_ext[k];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: capture the saturated sums on the FIN edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_ACT; k++) begin
        r_q[k] <= '0;
      end
    end else if (r_state == S_FIN) begin
      for (int k = 0; k < N_ACT; k++) begin
        r_q[k] <= w_sat[k];
      end
    end
  end

`ifdef QLAYER2_ARGMAX_EN
  logic [2:0] r_action;
  q88_t       w_best_val;
  logic [2:0] w_best_idx;

  // Argmax over the saturated sums; strict compare keeps the lowest index on ties.
  always_comb begin
    w_best_val = w_sat[0];
    w_best_idx = 3'd0;
    for (int k = 1; k < N_ACT; k++) begin
      w_best_idx = (w_sat[k] > w_best_val) ? 3'(k) : w_best_idx;
      w_best_val = (w_sat[k] > w_best_val) ? w_sat[k] : w_best_val;
    end
  end

  // Action register: updated together with the Q-values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_action <= 3'd0;
    end else if (r_state == S_FIN) begin
      r_action <= w_best_idx;
    end
  end

  assign action = r_action;
`endif

  assign idx  = r_idx;
  assign busy = r_busy;
  assign done = r_done;
  assign q_1  = r_q[0];
  assign q_2  = r_q[1];
  assign q_3  = r_q[2];
  assign q_4  = r_q[3];
  assign q_5  = r_q[4];

endmodule
